// File: rtl/atm_balance_ctrl.sv
// rtl/atm_balance_ctrl.sv - ATM session FSM with PIN check, deposit/withdraw and balance register
// Optional wrong-PIN lockout compiled in with `define ATM_PIN_LOCKOUT_EN.
module atm_balance_ctrl #(
   parameter logic [3:0] PIN       = 4'hA,
   parameter logic [7:0] INIT_BAL  = 8'd100,
   parameter int         MAX_TRIES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       card_in,
   input  logic [3:0] pin_in,
   input  logic [7:0] amount,
   input  logic       btn_enter,
   input  logic       btn_dep,
   input  logic       btn_wd,
   input  logic       btn_cancel,
   output logic [7:0] bal,
   output logic [2:0] state,
   output logic       err,
   output logic       locked
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PIN  = 3'd1;
   localparam logic [2:0] S_MENU = 3'd2;
   localparam logic [2:0] S_DEP  = 3'd3;
   localparam logic [2:0] S_WD   = 3'd4;
   localparam logic [2:0] S_LOCK = 3'd5;

   logic cancel_q, enter_q, dep_q, wd_q;
   logic p_cancel, p_enter, p_dep, p_wd;
   logic abort;
   logic [8:0] sum9;

   // Only the highest-priority edge survives: cancel > enter > dep > wd.
   always_comb begin
      p_cancel = btn_cancel & ~cancel_q;
      p_enter  = btn_enter  & ~enter_q & ~p_cancel;
      p_dep    = btn_dep    & ~dep_q   & ~p_cancel & ~p_enter;
      p_wd     = btn_wd     & ~wd_q    & ~p_cancel & ~p_enter & ~p_dep;
      abort    = ~card_in | p_cancel;
      sum9     = {1'b0, bal} + {1'b0, amount};
   end

`ifdef ATM_PIN_LOCKOUT_EN
   localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
   logic [TW-1:0] try_cnt;
`else
   assign locked = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         bal      <= INIT_BAL;
         err      <= 1'b0;
         // History held high so a button held through reset is not a press.
         cancel_q <= 1'b1;
         enter_q  <= 1'b1;
         dep_q    <= 1'b1;
         wd_q     <= 1'b1;
`ifdef ATM_PIN_LOCKOUT_EN
         locked   <= 1'b0;
         try_cnt  <= '0;
`endif
      end else begin
         cancel_q <= btn_cancel;
         enter_q  <= btn_enter;
         dep_q    <= btn_dep;
         wd_q     <= btn_wd;
         err      <= 1'b0;
         case (state)
            S_IDLE: if (card_in) state <= S_PIN;
            S_PIN: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (p_enter) begin
                  if (pin_in == PIN) begin
                     state <= S_MENU;
`ifdef ATM_PIN_LOCKOUT_EN
                     try_cnt <= '0;
`endif
                  end else begin
                     err <= 1'b1;
`ifdef ATM_PIN_LOCKOUT_EN
                     if (try_cnt == LAST_TRY) begin
                        state  <= S_LOCK;
                        locked <= 1'b1;
                     end else begin
                        try_cnt <= try_cnt + 1'b1;
                     end
`endif
                  end
               end
            end
            S_MENU: begin
               if (abort)      state <= S_IDLE;
               else if (p_dep) state <= S_DEP;
               else if (p_wd)  state <= S_WD;
            end
            S_DEP: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (p_enter) begin
                  state <= S_MENU;
                  if (!sum9[8]) bal <= sum9[7:0];
                  else          err <= 1'b1;
               end
            end
            S_WD: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (p_enter) begin
                  state <= S_MENU;
                  if (amount <= bal) bal <= bal - amount;
                  else               err <= 1'b1;
               end
            end
`ifdef ATM_PIN_LOCKOUT_EN
            S_LOCK: state <= S_LOCK;
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_balance_ctrl.sv
// tb/tb_atm_balance_ctrl.sv - directed self-checking bench for atm_balance_ctrl
module tb_atm_balance_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       card_in = 1'b0;
   logic [3:0] pin_in = 4'h0;
   logic [7:0] amount = 8'd0;
   logic       btn_enter = 1'b0, btn_dep = 1'b0, btn_wd = 1'b0, btn_cancel = 1'b0;
   logic [7:0] bal;
   logic [2:0] state;
   logic       err;
   logic       locked;

   int checks = 0;
   int errors = 0;

   atm_balance_ctrl dut (
      .clk(clk), .rst_n(rst_n), .card_in(card_in), .pin_in(pin_in), .amount(amount),
      .btn_enter(btn_enter), .btn_dep(btn_dep), .btn_wd(btn_wd), .btn_cancel(btn_cancel),
      .bal(bal), .state(state), .err(err), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic press_enter();
      btn_enter = 1'b1; tick(); btn_enter = 1'b0;
   endtask

   task automatic press_dep();
      btn_dep = 1'b1; tick(); btn_dep = 1'b0; tick();
   endtask

   task automatic press_wd();
      btn_wd = 1'b1; tick(); btn_wd = 1'b0; tick();
   endtask

   task automatic go_menu();
      card_in = 1'b1; tick();
      pin_in = 4'hA; press_enter(); tick();
   endtask

   task automatic test_reset();
      tick();
      card_in = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || bal !== 8'd100 || err !== 1'b0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL reset: state=%0d bal=%0d err=%b locked=%b, want 0/100/0/0", state, bal, err, locked);
      end
      tick();
      rst_n = 1'b1;
      card_in = 1'b0;
      tick();
   endtask

   task automatic test_deposit();
      do_reset();
      card_in = 1'b1; tick();
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL idle_to_pin: state=%0d want 1", state); end
      pin_in = 4'hA; press_enter();
      checks++;
      if (state !== 3'd2 || err !== 1'b0) begin errors++; $display("FAIL pin_ok: state=%0d err=%b want 2/0", state, err); end
      tick();
      press_enter(); tick();
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL menu_enter_ignored: state=%0d want 2", state); end
      press_dep();
      checks++;
      if (state !== 3'd3) begin errors++; $display("FAIL menu_to_dep: state=%0d want 3", state); end
      amount = 8'd50; press_enter();
      checks++;
      if (bal !== 8'd150 || state !== 3'd2 || err !== 1'b0) begin
         errors++; $display("FAIL dep_50: bal=%0d state=%0d err=%b want 150/2/0", bal, state, err);
      end
      tick();
   endtask

   task automatic test_withdraw();
      do_reset();
      go_menu();
      press_wd();
      checks++;
      if (state !== 3'd4) begin errors++; $display("FAIL menu_to_wd: state=%0d want 4", state); end
      amount = 8'd101; press_enter();
      checks++;
      if (bal !== 8'd100 || err !== 1'b1 || state !== 3'd2) begin
         errors++; $display("FAIL wd_over: bal=%0d err=%b state=%0d want 100/1/2", bal, err, state);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL wd_err_one_cycle: err=%b want 0", err); end
      press_wd();
      amount = 8'd100; press_enter();
      checks++;
      if (bal !== 8'd0 || err !== 1'b0) begin errors++; $display("FAIL wd_all: bal=%0d err=%b want 0/0", bal, err); end
      tick();
      press_wd();
      amount = 8'd0; press_enter();
      checks++;
      if (bal !== 8'd0 || err !== 1'b0 || state !== 3'd2) begin
         errors++; $display("FAIL wd_zero: bal=%0d err=%b state=%0d want 0/0/2", bal, err, state);
      end
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      go_menu();
      press_dep(); amount = 8'd100; press_enter(); tick();
      checks++;
      if (bal !== 8'd200) begin errors++; $display("FAIL dep_100: bal=%0d want 200", bal); end
      press_dep(); amount = 8'd56; press_enter();
      checks++;
      if (bal !== 8'd200 || err !== 1'b1) begin errors++; $display("FAIL dep_overflow: bal=%0d err=%b want 200/1", bal, err); end
      tick();
      press_dep(); amount = 8'd55; press_enter();
      checks++;
      if (bal !== 8'd255 || err !== 1'b0) begin errors++; $display("FAIL dep_to_255: bal=%0d err=%b want 255/0", bal, err); end
      tick();
      press_dep(); amount = 8'd0; press_enter();
      checks++;
      if (bal !== 8'd255 || err !== 1'b0) begin errors++; $display("FAIL dep_zero: bal=%0d err=%b want 255/0", bal, err); end
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      go_menu();
      press_dep();
      amount = 8'd20;
      btn_cancel = 1'b1; btn_enter = 1'b1; tick();
      btn_cancel = 1'b0; btn_enter = 1'b0;
      checks++;
      if (state !== 3'd0 || bal !== 8'd100 || err !== 1'b0) begin
         errors++; $display("FAIL dep_cancel_enter: state=%0d bal=%0d err=%b want 0/100/0", state, bal, err);
      end
      tick();
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL new_session: state=%0d want 1", state); end
      pin_in = 4'hA; press_enter(); tick();
      press_wd();
      amount = 8'd30;
      card_in = 1'b0; btn_enter = 1'b1; tick();
      btn_enter = 1'b0;
      checks++;
      if (state !== 3'd0 || bal !== 8'd100 || err !== 1'b0) begin
         errors++; $display("FAIL wd_card_removed: state=%0d bal=%0d err=%b want 0/100/0", state, bal, err);
      end
      tick();
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL idle_no_card: state=%0d want 0", state); end
      btn_enter = 1'b1; tick(); btn_enter = 1'b0; tick();
      checks++;
      if (state !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL idle_ignores_btn: state=%0d err=%b want 0/0", state, err); end
      go_menu();
      press_dep(); amount = 8'd7; press_enter(); tick();
      checks++;
      if (bal !== 8'd107) begin errors++; $display("FAIL bal_persists: bal=%0d want 107", bal); end
   endtask

   task automatic test_held_enter();
      btn_enter = 1'b1;
      card_in = 1'b1;
      pin_in = 4'h3;
      do_reset();
      tick(); tick();
      checks++;
      if (state !== 3'd1 || err !== 1'b0 || bal !== 8'd100) begin
         errors++; $display("FAIL held_enter: state=%0d err=%b bal=%0d want 1/0/100", state, err, bal);
      end
      btn_enter = 1'b0; tick();
      press_enter();
      checks++;
      if (state !== 3'd1 || err !== 1'b1) begin errors++; $display("FAIL enter_after_release: state=%0d err=%b want 1/1", state, err); end
      tick(); tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL single_eval: err=%b want 0", err); end
      pin_in = 4'hA; press_enter();
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL pin_after_wrong: state=%0d want 2", state); end
      tick();
   endtask

   task automatic test_wrong_pins();
      int npulse;
      do_reset();
      card_in = 1'b1; tick();
      pin_in = 4'h3;
      npulse = 0;
      for (int i = 0; i < 3; i++) begin
         press_enter();
         if (err === 1'b1) npulse++;
         tick();
      end
      checks++;
      if (npulse !== 3) begin errors++; $display("FAIL wrong_pin_pulses: got %0d want 3", npulse); end
`ifdef ATM_PIN_LOCKOUT_EN
      checks++;
      if (state !== 3'd5 || locked !== 1'b1) begin
         errors++; $display("FAIL lockout: state=%0d locked=%b want 5/1", state, locked);
      end
      card_in = 1'b0; tick(); tick();
      checks++;
      if (state !== 3'd5 || locked !== 1'b1) begin
         errors++; $display("FAIL lock_holds: state=%0d locked=%b want 5/1", state, locked);
      end
      do_reset();
      checks++;
      if (state !== 3'd0 || bal !== 8'd100 || locked !== 1'b0) begin
         errors++; $display("FAIL lock_reset: state=%0d bal=%0d locked=%b want 0/100/0", state, bal, locked);
      end
`else
      press_enter(); tick(); press_enter(); tick();
      checks++;
      if (state !== 3'd1 || locked !== 1'b0) begin
         errors++; $display("FAIL no_lockout: state=%0d locked=%b want 1/0", state, locked);
      end
      card_in = 1'b0; tick();
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL pin_card_removed: state=%0d want 0", state); end
`endif
   endtask

   initial begin
      test_reset();
      test_deposit();
      test_withdraw();
      test_overflow();
      test_priority();
      test_held_enter();
      test_wrong_pins();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/atm_balance_ctrl.md
ATM_BALANCE_CTRL -- requirements
Module: atm_balance_ctrl

Interface
REQ-001 SHALL have parameter PIN, default 4'hA, the correct 4-bit PIN.
REQ-002 SHALL have parameter INIT_BAL, default 8'd100, the balance loaded at reset.
REQ-003 SHALL have parameter MAX_TRIES, default 3, the wrong-PIN attempts allowed before lockout.
REQ-004 SHALL have port clk, input, 1, the single system clock (100 MHz), rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port card_in, input, 1, card-present level.
REQ-007 SHALL have port pin_in, input, 4, PIN value sampled on enter.
REQ-008 SHALL have port amount, input, 8, transaction amount sampled on enter.
REQ-009 SHALL have ports btn_enter, btn_dep, btn_wd and btn_cancel, each input, 1, synchronous button levels.
REQ-010 SHALL have port bal, output, 8, registered balance that feeds the balance display.
REQ-011 SHALL have port state, output, 3, registered state code.
REQ-012 SHALL have port err, output, 1, one-cycle registered error pulse.
REQ-013 SHALL have port locked, output, 1, registered lockout flag.

Function
REQ-014 SHALL register each button every cycle, and SHALL treat a press as a cycle where the button is 1 and its registered copy is 0.
REQ-015 SHALL act on only the highest-priority press in a cycle, with priority cancel > enter > dep > wd, and SHALL ignore all other presses in that cycle.
REQ-016 SHALL use state codes IDLE=0, PIN=1, MENU=2, DEP=3, WD=4, LOCK=5; codes 6 and 7 SHALL recover to IDLE on the next clock.
REQ-017 SHALL make all state, bal, err and locked updates on the clock edge of the press cycle, so outputs are visible the next cycle.
REQ-018 IDLE SHALL move to PIN when card_in=1; all buttons SHALL be ignored in IDLE.
REQ-019 In PIN, an enter press with pin_in==PIN SHALL move to MENU and clear the try counter.
REQ-020 In PIN, an enter press with pin_in!=PIN SHALL pulse err, stay in PIN and increment the try counter.
REQ-021 In MENU, a dep press SHALL move to DEP and a wd press SHALL move to WD; an enter press in MENU SHALL be ignored.
REQ-022 In DEP, an enter press SHALL move to MENU:
- if bal+amount ≤ 255 (9-bit compare), bal SHALL become bal+amount;
- otherwise bal SHALL stay unchanged and err SHALL pulse.
REQ-023 In WD, an enter press SHALL move to MENU:
- if amount ≤ bal, bal SHALL become bal-amount;
- otherwise bal SHALL stay unchanged and err SHALL pulse.
REQ-024 amount=0 SHALL be accepted in DEP and WD, with no bal change and no err.
REQ-025 A cancel press in PIN, MENU, DEP or WD SHALL move to IDLE and SHALL NOT change bal.
REQ-026 card_in=0 in PIN, MENU, DEP or WD SHALL move to IDLE; card removal SHALL take priority over any press in the same cycle.
REQ-027 bal SHALL persist across sessions, and only reset SHALL restore INIT_BAL.
REQ-028 err SHALL be high for exactly one cycle per error event, and 0 otherwise.

Reset
REQ-029 SHALL force, while rst_n=0 and independent of clk: state=IDLE, bal=INIT_BAL, err=0, locked=0, try counter=0.
REQ-030 SHALL set every button history register to 1 during reset, so a button held across reset release is not a press.
REQ-031 SHALL abandon any transaction in progress when reset asserts, with no partial bal update.

Configuration
REQ-032 SHALL use the macro ATM_PIN_LOCKOUT_EN to compile the lockout feature in or out.
REQ-033 With ATM_PIN_LOCKOUT_EN defined:
- the MAX_TRIES-th consecutive wrong PIN SHALL move to LOCK and set locked=1, together with the err pulse;
- LOCK SHALL ignore all inputs, including card_in, and SHALL be left only by reset.
REQ-034 Without ATM_PIN_LOCKOUT_EN:
- the try counter and LOCK state SHALL be absent;
- wrong PINs SHALL stay in PIN without limit;
- locked SHALL be tied to 0 and state SHALL never equal 5.

Verification
REQ-035 Reset, card_in=1, pin_in=4'hA, enter press -> MENU; then dep press, amount=50, enter press -> bal=150, state=MENU, err=0.
REQ-036 From MENU with bal=100: wd press, amount=101, enter press -> bal=100 and one err pulse; then amount=100, enter press -> bal=0.
REQ-037 With bal=200: deposit amount=56 -> err and bal=200; then deposit amount=55 -> bal=255.
REQ-038 With ATM_PIN_LOCKOUT_EN defined, three enter presses with pin_in=4'h3 -> three err pulses, state=5 and locked=1; card_in=0 -> still locked; rst_n pulse -> IDLE and bal=100.
REQ-039 In DEP, cancel and enter pressed in the same cycle -> IDLE with bal unchanged; in WD, card_in=0 in the same cycle as an enter press -> IDLE with bal unchanged.
REQ-040 btn_enter held high across rst_n release in PIN -> no action; the next 0→1 transition -> exactly one evaluation.
